mprj_io_arbiter: RTL and testbench

Time-shares the 16-bit user status field on `mprj_io[31:16]` between several user-project agents, so firmware checkpoints (e.g. 16'hAB60 / 16'hAB61) and hardware status words never collide on the pads. It sits inside the user project, between the agents and `io_out[31:16]`/`io_oeb[31:16]`. It grants the field round-robin, holds each word stable for a fixed number of cycles and acknowledges the requester.

---
 rtl/mprj_io_arbiter.sv | 93 +++++++++
 tb/tb_mprj_io_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_arbiter.sv
// mprj_io_arbiter: round-robin time-sharing of the user status field on
// mprj_io[31:16]. Each granted word is latched and driven for HOLD cycles,
// then the owner gets a one-cycle ack and the field returns to IDLE.
module mprj_io_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int HOLD = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [NREQ-1:0]  ack_o,
  output logic [DW-1:0]    io_out_o,
  output logic [DW-1:0]    io_oeb_o,
  output logic             busy_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [CW-1:0] hold_cnt;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] pick_next;
  logic [PW-1:0] scan_idx;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!pick_vld && req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
    pick_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
  end

  // Grant/hold state machine with registered pad word, enable and grant.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      grant_o  <= '0;
      io_out_o <= '0;
      io_oeb_o <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          // Pads release one edge after IDLE is seen with enable low.
          io_oeb_o <= {DW{~enable_i}};
          if (enable_i && pick_vld) begin
            state    <= ST_HOLD;
            grant_o  <= NREQ'(1) << pick_idx;
            hold_cnt <= CW'(HOLD - 1);
            rr_ptr   <= pick_next;
            io_out_o <= data_i[pick_idx*DW +: DW];
          end
        end
        default: begin
          io_oeb_o <= '0;
          if (hold_cnt == '0) begin
            state   <= ST_IDLE;
            grant_o <= '0;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Ack is decoded from registered state only: last hold cycle of the owner.
  assign ack_o  = (state == ST_HOLD && hold_cnt == '0) ? grant_o : '0;
  assign busy_o = (state == ST_HOLD);

endmodule

// File: tb/tb_mprj_io_arbiter.sv
// Directed bench for mprj_io_arbiter: a default build (NREQ=4, HOLD=8) and
// a HOLD=1 build with two requesters, both with hand-computed expectations.
module tb_mprj_io_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default build
  logic        rst, enable;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  grant, ack;
  logic [15:0] io_out, io_oeb;
  logic        busy;

  mprj_io_arbiter #(.NREQ(4), .DW(16), .HOLD(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .enable_i (enable),
    .req_i    (req),
    .data_i   (data),
    .grant_o  (grant),
    .ack_o    (ack),
    .io_out_o (io_out),
    .io_oeb_o (io_oeb),
    .busy_o   (busy)
  );

  // HOLD=1 build
  logic        r1_rst, r1_enable;
  logic [1:0]  r1_req;
  logic [31:0] r1_data;
  logic [1:0]  r1_grant, r1_ack;
  logic [15:0] r1_io_out, r1_io_oeb;
  logic        r1_busy;

  mprj_io_arbiter #(.NREQ(2), .DW(16), .HOLD(1)) dut1 (
    .wb_clk_i (clk),
    .wb_rst_i (r1_rst),
    .enable_i (r1_enable),
    .req_i    (r1_req),
    .data_i   (r1_data),
    .grant_o  (r1_grant),
    .ack_o    (r1_ack),
    .io_out_o (r1_io_out),
    .io_oeb_o (r1_io_oeb),
    .busy_o   (r1_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_grant"}, grant, 4'b0000);
    check({tag, "_ack"}, ack, 4'b0000);
    check({tag, "_io_out"}, io_out, 16'h0000);
    check({tag, "_oeb"}, io_oeb, 16'hFFFF);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [15:0] words [4];

  initial begin
    rst = 1'b1; enable = 1'b1; req = '0; data = '0;
    r1_rst = 1'b1; r1_enable = 1'b1; r1_req = '0; r1_data = '0;
    words[0] = 16'h1000; words[1] = 16'h1111; words[2] = 16'h2222; words[3] = 16'h3333;

    // Reset state
    tick(); tick();
    check_reset("rst0");

    // Single request from requester 2, then back-to-back from the same one
    rst = 1'b0;
    req = 4'b0100;
    data[47:32] = 16'hAB60;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t1_grant", grant, 4'b0100);
      check("t1_io_out", io_out, 16'hAB60);
      check("t1_oeb", io_oeb, 16'h0000);
      check("t1_busy", busy, 1'b1);
      check("t1_ack", ack, (i == 8) ? 4'b0100 : 4'b0000);
    end
    data[47:32] = 16'hAB61;
    tick();
    check("b2b_idle_grant", grant, 4'b0000);
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_io_out", io_out, 16'hAB60);
    check("b2b_idle_oeb", io_oeb, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("b2b_grant", grant, 4'b0100);
      check("b2b_io_out", io_out, 16'hAB61);
      check("b2b_ack", ack, (i == 8) ? 4'b0100 : 4'b0000);
      if (i == 3) begin
        // Data change and request drop mid-hold must not disturb the grant
        req = 4'b0000;
        data[47:32] = 16'hDEAD;
      end
    end
    tick();
    tick();
    check("drop_idle_grant", grant, 4'b0000);
    check("drop_idle_busy", busy, 1'b0);
    check("drop_keep_word", io_out, 16'hAB61);

    // All four requesting from reset: order 0,1,2,3,0, nine cycles apart
    rst = 1'b1;
    tick();
    check_reset("rst1");
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) data[k*16 +: 16] = words[k];
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_grant", grant, 4'b0001 << (g % 4));
      check("rr_io_out", io_out, words[g % 4]);
      repeat (7) tick();
      check("rr_ack", ack, 4'b0001 << (g % 4));
      tick();
      check("rr_idle_busy", busy, 1'b0);
    end

    // Enable falling mid-hold with requests pending (rr_ptr now at 1)
    tick();
    check("en_grant", grant, 4'b0010);
    tick(); tick();
    enable = 1'b0;
    repeat (5) tick();
    check("en_ack", ack, 4'b0010);
    check("en_hold_oeb", io_oeb, 16'h0000);
    tick();
    check("en_idle_grant", grant, 4'b0000);
    check("en_idle_busy", busy, 1'b0);
    tick();
    check("en_release_oeb", io_oeb, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_no_grant", grant, 4'b0000);
      check("en_oeb_hold", io_oeb, 16'hFFFF);
    end

    // Re-enable, then reset in the middle of the hold
    enable = 1'b1;
    tick();
    check("reen_grant", grant, 4'b0100);
    check("reen_io_out", io_out, 16'h2222);
    check("reen_oeb", io_oeb, 16'h0000);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check_reset("rst_mid");
    rst = 1'b0;
    req = 4'b0000;

    // HOLD=1 build: alternating one-cycle grants with same-cycle ack
    tick();
    r1_rst = 1'b0;
    r1_req = 2'b11;
    r1_data = {16'hBBBB, 16'hAAAA};
    for (int g = 0; g < 4; g++) begin
      tick();
      check("h1_grant", r1_grant, (g % 2 == 0) ? 2'b01 : 2'b10);
      check("h1_ack", r1_ack, (g % 2 == 0) ? 2'b01 : 2'b10);
      check("h1_io_out", r1_io_out, (g % 2 == 0) ? 16'hAAAA : 16'hBBBB);
      check("h1_busy", r1_busy, 1'b1);
      tick();
      check("h1_idle_grant", r1_grant, 2'b00);
      check("h1_idle_ack", r1_ack, 2'b00);
      check("h1_idle_busy", r1_busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
